key_debounce: RTL and testbench

Debounces and synchronises one raw, active-low push-button and turns it into clean single-cycle press and release events, plus optional hold-to-repeat events. Sits directly upstream of the LED counter's key inputs. Its `press_pulse` (ORed with `repeat_pulse` when wanted) drives the counter's increment/decrement/reset controls. One instance is used per key.

---
 rtl/key_debounce.sv | 145 ++++++++++++++
 tb/tb_key_debounce.sv | 120 ++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// ============================================================================
// Module   : key_debounce
// Purpose  : Synchronises and debounces one active-low push-button into a
//            clean level plus single-cycle press/release (and optional
//            repeat) strobes. Optional feature macro: KEY_DEBOUNCE_REPEAT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REP_W           = 26
) (
  input  logic clk,
  input  logic reset_key,
  input  logic key,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  // Parameter legality is enforced at elaboration so a bad build never links.
  if ((DEBOUNCE_CYCLES < 2) || (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) ||
      (REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2) ||
      (64'(REPEAT_DELAY) > (64'd1 << REP_W)) ||
      (64'(REPEAT_PERIOD) > (64'd1 << REP_W))) begin : g_bad_params
    $error("key_debounce: illegal parameter combination");
  end

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_key) begin
    if (!reset_key) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      r_sync1       <= key;
      r_sync2       <= r_sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_sync2) begin
            r_state <= S_PRESS_WAIT;
            r_cnt   <= C_CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (r_sync2) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state     <= S_HELD;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        S_HELD: begin
          if (r_sync2) begin
            r_state <= S_RELEASE_WAIT;
            r_cnt   <= C_CNT_ONE;
          end
        end
        default: begin
          if (!r_sync2) begin
            r_state <= S_HELD;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state       <= S_IDLE;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [REP_W-1:0] C_REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] C_REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] C_REP_ONE   = REP_W'(1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_first_done;
  logic [REP_W-1:0] w_rep_limit;

  assign w_rep_limit = r_first_done ? C_REP_NEXT : C_REP_FIRST;

  // Counts only while HELD, freezes across a release glitch, and is held
  // cleared before entry to HELD so every accepted press starts afresh.
  always_ff @(posedge clk or negedge reset_key) begin
    if (!reset_key) begin
      r_rep_cnt    <= '0;
      r_first_done <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (r_state == S_HELD) begin
        if (r_rep_cnt == w_rep_limit) begin
          r_rep_cnt    <= '0;
          r_first_done <= 1'b1;
          repeat_pulse <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + C_REP_ONE;
        end
      end else if (r_state != S_RELEASE_WAIT) begin
        r_rep_cnt    <= '0;
        r_first_done <= 1'b0;
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// Module   : tb_key_debounce
// Purpose  : Directed self-checking bench for key_debounce (DEBOUNCE=4,
//            REPEAT_DELAY=10, REPEAT_PERIOD=3); honours KEY_DEBOUNCE_REPEAT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_key;
  logic key;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REP_W          (26)
  ) dut (
    .clk          (clk),
    .reset_key    (reset_key),
    .key          (key),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector order: {pressed, press_pulse, release_pulse, repeat_pulse}
  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {pressed, press_pulse, release_pulse, repeat_pulse};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with key released
    key       = 1'b1;
    reset_key = 1'b0;
    #1;
    check("reset_t0", 4'b0000);
    tick();
    tick();
    check("reset_held", 4'b0000);
    reset_key = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle_%0d", i), 4'b0000);
    end

    // Clean press sampled first at edge 0, then held for repeats (P = 5)
    key = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      tick();
      check($sformatf("press_hold_%0d", i),
            {i >= 5, i == 5, 1'b0,
             REP_ON && (i == 15 || i == 18 || i == 21 || i == 24)});
    end

    // Release with a one-sample glitch: final rising sample at edge 3
    for (int i = 0; i <= 11; i++) begin
      key = (i == 2) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("release_%0d", i),
            {i < 8, 1'b0, i == 8, REP_ON && (i == 1)});
    end

    // Bounce: low 3, high 1, then low; final falling sample at edge 4
    for (int i = 0; i <= 12; i++) begin
      key = (i == 3) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("bounce_%0d", i), {i >= 9, i == 9, 1'b0, 1'b0});
    end

    // Reset while held: immediate clear, then a fresh full debounce
    reset_key = 1'b0;
    #1;
    check("rst_held_async", 4'b0000);
    tick();
    tick();
    check("rst_held_during", 4'b0000);
    reset_key = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      tick();
      check($sformatf("rst_repress_%0d", i), {i >= 5, i == 5, 1'b0, 1'b0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
